sensor_frame_rx: RTL and testbench

SENSOR_FRAME_RX -- requirements
Module: sensor_frame_rx

---
 rtl/sensor_frame_pkg.sv | 31 +++
 rtl/sensor_frame_rx_if.sv | 27 ++
 rtl/sensor_gap_timer.sv | 42 ++++
 rtl/sensor_frame_rx.sv | 138 +++++++++++++
 tb/tb_sensor_frame_rx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sensor_frame_pkg.sv
// Shared definitions for the sensor serial frame format.
// Used by the receiver (sensor_frame_rx) and the existing transmitter.
package sensor_frame_pkg;

  localparam int unsigned FRAME_W   = 12;
  localparam int unsigned SYNC_W    = 3;
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned BIT_CNT_W = 3;
  localparam int unsigned FCNT_W    = 16;
  localparam int unsigned ECNT_W    = 8;

  localparam logic [SYNC_W-1:0] SYNC_PAT = 3'b101;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_CHECK  = 2'd3
  } state_e;

  // Even parity over payload plus parity bit.
  function automatic logic parity_ok(input logic [PAYLOAD_W-1:0] payload, input logic par);
    return ~((^payload) ^ par);
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
    return (v == '1) ? v : v + ECNT_W'(1);
  endfunction

endpackage

// File: rtl/sensor_frame_rx_if.sv
// Serial bit input and receive-status bundle of the sensor frame receiver.
//   data_in/data_valid : serial bit and its strobe (driven by master)
//   rx_data/rx_valid   : last good payload and its update pulse
//   parity_err/gap_err : error pulses
//   frame_count        : good frames (wrapping), err_count : errors (saturating)
interface sensor_frame_rx_if;
  import sensor_frame_pkg::*;

  logic                 data_in;
  logic                 data_valid;
  logic [PAYLOAD_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 gap_err;
  logic [FCNT_W-1:0]    frame_count;
  logic [ECNT_W-1:0]    err_count;

  modport master (
    output data_in, data_valid,
    input  rx_data, rx_valid, parity_err, gap_err, frame_count, err_count
  );

  modport slave (
    input  data_in, data_valid,
    output rx_data, rx_valid, parity_err, gap_err, frame_count, err_count
  );
endinterface

// File: rtl/sensor_gap_timer.sv
// Counts consecutive idle ticks while enabled; flags the tick that completes
// GAP_TIMEOUT idle cycles.
//   clk, reset : clock, async active-low reset
//   enable     : counting allowed (otherwise held at zero)
//   clear      : restart the idle run (a bit arrived)
//   tick       : this cycle is idle
//   expired    : combinational, high on the GAP_TIMEOUT-th consecutive idle tick
module sensor_gap_timer #(
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] count_q, count_d;

  // Next count and expiry detect.
  always_comb begin
    count_d = count_q;
    expired = 1'b0;
    if (!enable || clear) begin
      count_d = '0;
    end else if (tick) begin
      if (count_q == CNT_W'(GAP_TIMEOUT - 1)) begin
        count_d = '0;
        expired = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/sensor_frame_rx.sv
// Sensor serial frame receiver: hunts for the 1,0,1 sync with a sliding
// window, collects 8 payload bits LSB first and an even parity bit, and
// reports good frames, parity failures and mid-frame gap aborts.
//   clk, reset : clock, async active-low reset
//   bus        : slave side of sensor_frame_rx_if (serial in, status out)
module sensor_frame_rx
  import sensor_frame_pkg::*;
#(
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  sensor_frame_rx_if.slave bus
);

  state_e               state_q, state_d;
  logic [SYNC_W-1:0]    window_q, window_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [PAYLOAD_W-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 gap_err_q, gap_err_d;
  logic [FCNT_W-1:0]    frame_count_q, frame_count_d;
  logic [ECNT_W-1:0]    err_count_q, err_count_d;
  logic                 gap_en_c;
  logic                 gap_expired_c;

  // Idle cycles only matter once a frame has synced.
  assign gap_en_c = (state_q == S_DATA) || (state_q == S_PARITY);

  sensor_gap_timer #(.GAP_TIMEOUT(GAP_TIMEOUT)) u_gap_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (gap_en_c),
    .clear   (bus.data_valid),
    .tick    (~bus.data_valid),
    .expired (gap_expired_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    window_d      = window_q;
    bit_cnt_d     = bit_cnt_q;
    payload_d     = payload_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    parity_err_d  = 1'b0;
    gap_err_d     = 1'b0;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;

    case (state_q)
      S_HUNT: begin
        if (bus.data_valid) begin
          window_d = {window_q[SYNC_W-2:0], bus.data_in};
          if (window_d == SYNC_PAT) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (bus.data_valid) begin
          payload_d = {bus.data_in, payload_q[PAYLOAD_W-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(PAYLOAD_W - 1)) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bus.data_valid) begin
          state_d = S_CHECK;
          if (parity_ok(payload_q, bus.data_in)) begin
            rx_valid_d    = 1'b1;
            rx_data_d     = payload_q;
            frame_count_d = frame_count_q + FCNT_W'(1);
          end else begin
            parity_err_d = 1'b1;
            err_count_d  = sat_inc(err_count_q);
          end
        end
      end
      S_CHECK: begin
        // Bits arriving here are dropped on purpose.
        state_d  = S_HUNT;
        window_d = '0;
      end
      default: begin
        state_d  = S_HUNT;
        window_d = '0;
      end
    endcase

    // Expiry only fires on an idle cycle in S_DATA/S_PARITY, so it never
    // collides with a bit accepted above.
    if (gap_expired_c) begin
      state_d     = S_HUNT;
      window_d    = '0;
      gap_err_d   = 1'b1;
      err_count_d = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_HUNT;
      window_q      <= '0;
      bit_cnt_q     <= '0;
      payload_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      parity_err_q  <= 1'b0;
      gap_err_q     <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      bit_cnt_q     <= bit_cnt_d;
      payload_q     <= payload_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      parity_err_q  <= parity_err_d;
      gap_err_q     <= gap_err_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.parity_err  = parity_err_q;
  assign bus.gap_err     = gap_err_q;
  assign bus.frame_count = frame_count_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Self-checking bench for sensor_frame_rx.
module tb_sensor_frame_rx;
  import sensor_frame_pkg::*;

  localparam int unsigned GAP = 16;

  typedef logic bit_q_t[$];
  typedef enum int {EV_RX = 0, EV_PAR = 1, EV_GAP = 2} ev_kind_e;
  typedef struct {
    int unsigned cyc;
    ev_kind_e    kind;
    logic [7:0]  data;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          viol = 0;
  bit          prev_pulse = 1'b0;
  ev_t         evq[$];

  // Reference model state: plain integers, wrap/saturation applied on compare.
  int          exp_frames = 0;
  int          exp_errs = 0;
  logic [7:0]  exp_data = 8'h00;

  sensor_frame_rx_if bus();

  sensor_frame_rx #(.GAP_TIMEOUT(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every status pulse with the index of the edge that raised it.
  always @(negedge clk) begin
    int n;
    n = int'(bus.rx_valid) + int'(bus.parity_err) + int'(bus.gap_err);
    if (n > 1 || (n > 0 && prev_pulse)) viol++;
    prev_pulse = (n > 0);
    if (bus.rx_valid)   evq.push_back('{cyc, EV_RX, bus.rx_data});
    if (bus.parity_err) evq.push_back('{cyc, EV_PAR, bus.rx_data});
    if (bus.gap_err)    evq.push_back('{cyc, EV_GAP, bus.rx_data});
  end

  function automatic logic [7:0] exp_err8();
    return (exp_errs > 255) ? 8'hFF : 8'(exp_errs);
  endfunction

  function automatic logic [34:0] out_vec();
    return {bus.rx_data, bus.rx_valid, bus.parity_err, bus.gap_err, bus.frame_count, bus.err_count};
  endfunction

  function automatic logic even_par(input logic [7:0] p);
    return 1'($countones(p));
  endfunction

  function automatic bit_q_t frame_bits(input logic [7:0] p, input logic par);
    bit_q_t q;
    q = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) q.push_back(p[i]);
    q.push_back(par);
    return q;
  endfunction

  function automatic int find_sync(input bit_q_t s);
    for (int i = 0; i + 2 < s.size(); i++)
      if (s[i] && !s[i+1] && s[i+2]) return i;
    return -1;
  endfunction

  task automatic drive(input logic v, input logic b);
    bus.data_valid = v;
    bus.data_in    = b;
    @(posedge clk);
    #1;
  endtask

  // Send bits with up to max_gap random idle cycles between them.
  task automatic send_stream(input bit_q_t bits, input int unsigned max_gap, output int unsigned last_cyc);
    foreach (bits[i]) begin
      if (i > 0) repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'($urandom));
      drive(1'b1, bits[i]);
    end
    last_cyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_vec() !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", out_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0);
    evq.delete();
  endtask

  task automatic test_good_a5();
    int unsigned pc;
    evq.delete();
    send_stream(frame_bits(8'hA5, 1'b0), 0, pc);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    exp_frames++;
    exp_data = 8'hA5;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_RX || evq[0].cyc != pc || evq[0].data !== 8'hA5) begin
      failures++;
      $display("FAIL good_a5_event: n=%0d kind=%0d cyc=%0d data=%h want n=1 kind=0 cyc=%0d data=a5",
               evq.size(), evq[0].kind, evq[0].cyc, evq[0].data, pc);
    end
    checks++;
    if (bus.rx_data !== 8'hA5 || bus.frame_count !== 16'd1 || bus.err_count !== 8'd0) begin
      failures++;
      $display("FAIL good_a5_status: data=%h fc=%0d ec=%0d want a5 1 0", bus.rx_data, bus.frame_count, bus.err_count);
    end
  endtask

  task automatic test_parity_err();
    int unsigned pc;
    evq.delete();
    send_stream(frame_bits(8'h01, 1'b0), 0, pc);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    exp_errs++;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_PAR || evq[0].cyc != pc) begin
      failures++;
      $display("FAIL parity_err_event: n=%0d kind=%0d cyc=%0d want n=1 kind=1 cyc=%0d",
               evq.size(), evq[0].kind, evq[0].cyc, pc);
    end
    checks++;
    if (bus.rx_data !== exp_data || bus.err_count !== exp_err8() || bus.frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL parity_err_status: data=%h ec=%0d fc=%0d want %h %0d %0d",
               bus.rx_data, bus.err_count, bus.frame_count, exp_data, exp_err8(), 16'(exp_frames));
    end
  endtask

  task automatic test_sliding_sync();
    int unsigned pc;
    bit_q_t s;
    bit_q_t f;
    evq.delete();
    s = '{1'b0, 1'b1, 1'b1};
    f = frame_bits(8'h3C, even_par(8'h3C));
    foreach (f[k]) s.push_back(f[k]);
    send_stream(s, 0, pc);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    exp_frames++;
    exp_data = 8'h3C;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_RX || evq[0].cyc != pc || evq[0].data !== 8'h3C) begin
      failures++;
      $display("FAIL sliding_sync: n=%0d kind=%0d cyc=%0d data=%h want n=1 kind=0 cyc=%0d data=3c",
               evq.size(), evq[0].kind, evq[0].cyc, evq[0].data, pc);
    end
  endtask

  task automatic test_gap();
    int unsigned pc;
    int unsigned gc;
    bit_q_t g;
    evq.delete();
    g = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    send_stream(g, 0, pc);
    repeat (GAP - 1) drive(1'b0, 1'($urandom));
    g = '{1'b1, 1'b0};
    send_stream(g, 0, pc);
    checks++;
    if (evq.size() != 0) begin
      failures++;
      $display("FAIL gap_boundary: %0d pulses after %0d idle cycles then a bit, want 0", evq.size(), GAP - 1);
    end
    repeat (GAP) drive(1'b0, 1'($urandom));
    gc = cyc;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    exp_errs++;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_GAP || evq[0].cyc != gc) begin
      failures++;
      $display("FAIL gap_timeout: n=%0d kind=%0d cyc=%0d want n=1 kind=2 cyc=%0d",
               evq.size(), evq[0].kind, evq[0].cyc, gc);
    end
    checks++;
    if (bus.err_count !== exp_err8()) begin
      failures++;
      $display("FAIL gap_err_count: got %0d want %0d", bus.err_count, exp_err8());
    end
    evq.delete();
    send_stream(frame_bits(8'h7E, even_par(8'h7E)), 0, pc);
    drive(1'b0, 1'b0);
    exp_frames++;
    exp_data = 8'h7E;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_RX || evq[0].data !== 8'h7E || bus.frame_count !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL gap_recover: n=%0d kind=%0d data=%h fc=%0d want n=1 kind=0 data=7e fc=%0d",
               evq.size(), evq[0].kind, evq[0].data, bus.frame_count, 16'(exp_frames));
    end
  endtask

  task automatic test_reset_mid();
    int unsigned pc;
    bit_q_t g;
    g = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send_stream(g, 0, pc);
    bus.data_valid = 1'b1;
    bus.data_in = 1'b1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (out_vec() !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h want 0", out_vec());
    end
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    checks++;
    if (out_vec() !== 35'd0) begin
      failures++;
      $display("FAIL reset_mid_held: got %h want 0", out_vec());
    end
    evq.delete();
    @(negedge clk);
    reset = 1'b1;
    bus.data_valid = 1'b0;
    drive(1'b0, 1'b0);
    exp_frames = 0;
    exp_errs = 0;
    exp_data = 8'h00;
    send_stream(frame_bits(8'hFF, even_par(8'hFF)), 0, pc);
    drive(1'b0, 1'b0);
    exp_frames++;
    exp_data = 8'hFF;
    checks++;
    if (evq.size() != 1 || evq[0].kind != EV_RX || evq[0].cyc != pc || evq[0].data !== 8'hFF) begin
      failures++;
      $display("FAIL reset_mid_frame: n=%0d kind=%0d cyc=%0d data=%h want n=1 kind=0 cyc=%0d data=ff",
               evq.size(), evq[0].kind, evq[0].cyc, evq[0].data, pc);
    end
    checks++;
    if (bus.frame_count !== 16'd1 || bus.err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_counts: fc=%0d ec=%0d want 1 0", bus.frame_count, bus.err_count);
    end
  endtask

  // A bit during the check cycle followed by 0,1 would sync early if accepted.
  task automatic test_back_to_back();
    int unsigned pc1;
    int unsigned pc2;
    logic [7:0] p1;
    p1 = 8'($urandom);
    evq.delete();
    send_stream(frame_bits(p1, even_par(p1)), 0, pc1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    send_stream(frame_bits(8'h5A, even_par(8'h5A)), 0, pc2);
    drive(1'b0, 1'b0);
    exp_frames += 2;
    exp_data = 8'h5A;
    checks++;
    if (evq.size() != 2 || evq[0].kind != EV_RX || evq[0].cyc != pc1 || evq[0].data !== p1 ||
        evq[1].kind != EV_RX || evq[1].cyc != pc2 || evq[1].data !== 8'h5A) begin
      failures++;
      $display("FAIL back_to_back: n=%0d first=%0d/%0d/%h second=%0d/%0d/%h want 0/%0d/%h 0/%0d/5a",
               evq.size(), evq[0].kind, evq[0].cyc, evq[0].data, evq[1].kind, evq[1].cyc, evq[1].data,
               pc1, p1, pc2);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      logic [7:0]  p;
      logic        par;
      logic [7:0]  mp;
      bit_q_t      j;
      bit_q_t      f;
      bit_q_t      s;
      int          sp;
      int unsigned pc;
      bit          good;
      ev_kind_e    k;
      p   = 8'($urandom);
      par = even_par(p) ^ ($urandom_range(3, 0) == 0);
      repeat ($urandom_range(4, 0)) j.push_back(1'($urandom));
      f = frame_bits(p, par);
      s = j;
      foreach (f[x]) s.push_back(f[x]);
      if (find_sync(s) != j.size()) s = f;
      // Model: locate the sync, read payload and parity from the stream.
      sp = find_sync(s);
      mp = 8'h00;
      for (int b = 0; b < 8; b++) mp[b] = s[sp + 3 + b];
      good = (($countones(mp) + int'(s[sp + 11])) % 2) == 0;
      k = good ? EV_RX : EV_PAR;
      if (good) begin
        exp_frames++;
        exp_data = mp;
      end else begin
        exp_errs++;
      end
      evq.delete();
      send_stream(s, $urandom_range(3, 0), pc);
      drive(1'b0, 1'($urandom));
      repeat ($urandom_range(2, 0)) drive(1'b0, 1'($urandom));
      checks++;
      if (evq.size() != 1 || evq[0].kind != k || evq[0].cyc != pc || (good && evq[0].data !== mp)) begin
        failures++;
        $display("FAIL random_event[%0d]: n=%0d kind=%0d cyc=%0d data=%h want n=1 kind=%0d cyc=%0d data=%h",
                 it, evq.size(), evq[0].kind, evq[0].cyc, evq[0].data, k, pc, mp);
      end
      checks++;
      if (bus.rx_data !== exp_data || bus.frame_count !== 16'(exp_frames) || bus.err_count !== exp_err8()) begin
        failures++;
        $display("FAIL random_status[%0d]: data=%h fc=%0d ec=%0d want %h %0d %0d",
                 it, bus.rx_data, bus.frame_count, bus.err_count, exp_data, 16'(exp_frames), exp_err8());
      end
    end
  endtask

  task automatic test_err_saturate();
    int unsigned pc;
    int npar;
    evq.delete();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] p;
      p = 8'($urandom);
      send_stream(frame_bits(p, ~even_par(p)), 0, pc);
      drive(1'b0, 1'b0);
    end
    exp_errs += 256;
    npar = 0;
    foreach (evq[i]) if (evq[i].kind == EV_PAR) npar++;
    checks++;
    if (npar != 256 || evq.size() != 256) begin
      failures++;
      $display("FAIL saturate_pulses: parity pulses=%0d total=%0d want 256 256", npar, evq.size());
    end
    checks++;
    if (bus.err_count !== 8'hFF || bus.rx_data !== exp_data) begin
      failures++;
      $display("FAIL saturate_count: ec=%h data=%h want ff %h", bus.err_count, bus.rx_data, exp_data);
    end
  endtask

  task automatic test_frame_wrap();
    int unsigned pc;
    logic [7:0] p;
    @(negedge clk);
    force dut.frame_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_q;
    exp_frames = 65535;
    #1;
    checks++;
    if (bus.frame_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload: fc=%h want ffff", bus.frame_count);
    end
    p = 8'($urandom);
    evq.delete();
    send_stream(frame_bits(p, even_par(p)), 1, pc);
    drive(1'b0, 1'b0);
    exp_frames++;
    exp_data = p;
    checks++;
    if (bus.frame_count !== 16'(exp_frames) || evq.size() != 1 || evq[0].kind != EV_RX || bus.rx_data !== p) begin
      failures++;
      $display("FAIL wrap_count: fc=%h n=%0d data=%h want %h 1 %h",
               bus.frame_count, evq.size(), bus.rx_data, 16'(exp_frames), p);
    end
  endtask

  task automatic test_pulse_exclusive();
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL pulse_exclusive: %0d overlapping or consecutive pulses, want 0", viol);
    end
  endtask

  initial begin
    bus.data_valid = 1'b0;
    bus.data_in = 1'b0;
    test_reset();
    test_good_a5();
    test_parity_err();
    test_sliding_sync();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_err_saturate();
    test_frame_wrap();
    test_pulse_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
